// File: rtl/coverfloat_pkg.sv
// coverfloat_pkg: shared types and record layout for the coverfloat vector loader.
//  CF_VEC_WORDS       words per covervector record
//  CF_IDX_*           word index where each field starts (multi-word fields are LS word first)
//  loaderState_t      loader FSM states
//  coverfloat_vec_t   all coverage-interface fields of one record
//  cfInsertWord       returns a record with one input word placed at its layout position
package coverfloat_pkg;

    localparam int CF_VEC_WORDS      = 26;
    localparam int CF_IDX_OP         = 0;
    localparam int CF_IDX_FMT        = 1;
    localparam int CF_IDX_A          = 2;
    localparam int CF_IDX_B          = 6;
    localparam int CF_IDX_C          = 10;
    localparam int CF_IDX_RESULT     = 14;
    localparam int CF_IDX_INTERM_X   = 18;
    localparam int CF_IDX_INTERM_S   = 19;
    localparam int CF_IDX_INTERM_M   = 20;
    localparam int CF_IDX_LAST       = CF_VEC_WORDS - 1;

    typedef enum logic [1:0] {
        COLLECT,
        FULL,
        DISCARD
    } loaderState_t;

    typedef struct packed {
        logic [31:0]  op;
        logic [7:0]   rm;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [7:0]   operandFmt;
        logic [127:0] result;
        logic [7:0]   resultFmt;
        logic         intermS;
        logic [31:0]  intermX;
        logic [191:0] intermM;
        logic [7:0]   exceptionBits;
    } coverfloat_vec_t;

    function automatic coverfloat_vec_t cfInsertWord(input coverfloat_vec_t v, input logic [4:0] idx,
                                                     input logic [31:0] w);
        coverfloat_vec_t r;
        int i;
        r = v;
        i = int'(idx);
        if (i == CF_IDX_OP)
            r.op = w;
        else if (i == CF_IDX_FMT)
            {r.rm, r.operandFmt, r.resultFmt, r.exceptionBits} = w;
        else if (i < CF_IDX_B)
            r.a[32*(i-CF_IDX_A) +: 32] = w;
        else if (i < CF_IDX_C)
            r.b[32*(i-CF_IDX_B) +: 32] = w;
        else if (i < CF_IDX_RESULT)
            r.c[32*(i-CF_IDX_C) +: 32] = w;
        else if (i < CF_IDX_INTERM_X)
            r.result[32*(i-CF_IDX_RESULT) +: 32] = w;
        else if (i == CF_IDX_INTERM_X)
            r.intermX = w;
        else if (i == CF_IDX_INTERM_S)
            r.intermS = w[0];
        else if (i < CF_VEC_WORDS)
            r.intermM[32*(i-CF_IDX_INTERM_M) +: 32] = w;
        return r;
    endfunction

endpackage

// File: rtl/coverfloat_vector_loader.sv
// coverfloat_vector_loader: assembles 26-word covervector records from a word stream and presents them
// on the coverfloat coverage-interface fields with a valid/ready handshake.
//  clk, rst_n                   clock, asynchronous active-low reset
//  in_valid/in_ready/in_data/in_last   input word stream
//  out_valid/out_ready          record handshake toward the coverage sampler
//  op..exceptionBits            fields of the held record
//  vec_count                    delivered-record counter (wraps)
//  frame_err, rsvd_err          sticky error flags; clear_err clears both (a same-cycle set wins)
module coverfloat_vector_loader
    import coverfloat_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      op,
    output logic [7:0]       rm,
    output logic [127:0]     a,
    output logic [127:0]     b,
    output logic [127:0]     c,
    output logic [7:0]       operandFmt,
    output logic [127:0]     result,
    output logic [7:0]       resultFmt,
    output logic             intermS,
    output logic [31:0]      intermX,
    output logic [191:0]     intermM,
    output logic [7:0]       exceptionBits,
    output logic [CNT_W-1:0] vec_count,
    output logic             frame_err,
    output logic             rsvd_err,
    input  logic             clear_err
);

    loaderState_t    state;
    logic [4:0]      idx;
    coverfloat_vec_t asmBuf;
    coverfloat_vec_t outReg;
    coverfloat_vec_t nextBuf;
    logic            accept;
    logic            collecting;
    logic            isLast;
    logic            drain;
    logic            canLoad;
    logic            recordDone;
    logic            loadOut;
    logic            frameSet;
    logic            rsvdSet;

    // in_ready is decoded from the registered state only, never from out_ready
    assign in_ready = state != FULL;

    always_comb begin
        collecting = state == COLLECT;
        accept     = in_valid && in_ready;
        isLast     = idx == 5'(CF_IDX_LAST);
        drain      = out_valid && out_ready;
        canLoad    = !out_valid || out_ready;
        nextBuf    = cfInsertWord(asmBuf, idx, in_data);
        recordDone = accept && collecting && isLast && in_last;
        loadOut    = canLoad && (recordDone || state == FULL);
        frameSet   = accept && collecting && (in_last != isLast);
        rsvdSet    = accept && collecting && idx == 5'(CF_IDX_INTERM_S) && |in_data[31:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            asmBuf    <= '0;
            outReg    <= '0;
            out_valid <= 1'b0;
            vec_count <= '0;
            frame_err <= 1'b0;
            rsvd_err  <= 1'b0;
        end else begin
            if (accept && collecting)
                asmBuf <= nextBuf;
            // a record finishing this cycle bypasses the buffer so it appears one cycle after its last word
            if (loadOut)
                outReg <= recordDone ? nextBuf : asmBuf;
            out_valid <= loadOut || (out_valid && !out_ready);
            if (drain)
                vec_count <= vec_count + CNT_W'(1);
            frame_err <= frameSet || (frame_err && !clear_err);
            rsvd_err  <= rsvdSet || (rsvd_err && !clear_err);
            case (state)
                COLLECT: if (accept) begin
                    idx <= (in_last || isLast) ? 5'd0 : idx + 5'd1;
                    if (isLast && !in_last)
                        state <= DISCARD;
                    else if (recordDone && !canLoad)
                        state <= FULL;
                end
                FULL:    if (canLoad) state <= COLLECT;
                DISCARD: if (accept && in_last) state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

    assign op            = outReg.op;
    assign rm            = outReg.rm;
    assign a             = outReg.a;
    assign b             = outReg.b;
    assign c             = outReg.c;
    assign operandFmt    = outReg.operandFmt;
    assign result        = outReg.result;
    assign resultFmt     = outReg.resultFmt;
    assign intermS       = outReg.intermS;
    assign intermX       = outReg.intermX;
    assign intermM       = outReg.intermM;
    assign exceptionBits = outReg.exceptionBits;

endmodule
